frog_grid_mover: RTL and testbench

- Parametrised successor to the first-generation frog mover: grid-based player position controller for the Frogger display pipeline.
- Turns debounced direction levels into single-cell hops:
  - edge detect and hold-to-repeat
  - hop cooldown
  - boundary clamping
  - goal detection, hazard death with respawn delay, lives and game-over
- Feeds pixel coordinates to the sprite renderer; takes a hazard flag from the collision block.

---
 rtl/frogger_pkg.sv | 26 ++
 rtl/dir_edge_repeat.sv | 69 ++++++
 rtl/frog_grid_mover.sv | 207 ++++++++++++++++++++
 tb/tb_frog_grid_mover.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared types and default grid geometry for the Frogger player mover.
package frogger_pkg;

  localparam int unsigned DEF_GRID_W    = 20;
  localparam int unsigned DEF_GRID_H    = 15;
  localparam int unsigned DEF_CELL_W    = 32;
  localparam int unsigned DEF_CELL_H    = 32;
  localparam int unsigned DEF_START_COL = 10;
  localparam int unsigned DEF_START_ROW = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOP  = 2'd1,
    ST_DEAD = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

endpackage

// File: rtl/dir_edge_repeat.sv
// Priority direction select with rising-edge trigger and hold-to-repeat.
module dir_edge_repeat
  import frogger_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic i_Clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic en,
  input  logic hop,
  output dir_t dir_c,
  output logic trig_c
);

  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

  logic [3:0]       prev_q;
  dir_t             sel_q;
  logic [RPT_W-1:0] rpt_q;
  logic [RPT_W-1:0] rpt_d;
  logic             cur_lvl;
  logic             prev_lvl;
  logic             held;

  // Priority select Up > Down > Left > Right and the trigger decision.
  always_comb begin
    dir_c    = DIR_NONE;
    cur_lvl  = 1'b0;
    prev_lvl = 1'b0;
    if (up) begin
      dir_c = DIR_UP;    cur_lvl = 1'b1; prev_lvl = prev_q[3];
    end else if (down) begin
      dir_c = DIR_DOWN;  cur_lvl = 1'b1; prev_lvl = prev_q[2];
    end else if (left) begin
      dir_c = DIR_LEFT;  cur_lvl = 1'b1; prev_lvl = prev_q[1];
    end else if (right) begin
      dir_c = DIR_RIGHT; cur_lvl = 1'b1; prev_lvl = prev_q[0];
    end
    held   = (dir_c != DIR_NONE) && (dir_c == sel_q);
    trig_c = en && cur_lvl && (!prev_lvl || (held && (rpt_q == RPT_MAX)));
  end

  // Repeat counter: consecutive enabled cycles with an unchanged selection.
  always_comb begin
    rpt_d = '0;
    if (en && !hop && held) begin
      rpt_d = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1);
    end
  end

  // Previous levels and selection track every cycle, enabled or not.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      sel_q  <= DIR_NONE;
      rpt_q  <= '0;
    end else begin
      prev_q <= {up, down, left, right};
      sel_q  <= dir_c;
      rpt_q  <= rpt_d;
    end
  end

endmodule

// File: rtl/frog_grid_mover.sv
// Grid-based frog position controller: hops, cooldown, goal, hazard death, lives.
module frog_grid_mover
  import frogger_pkg::*;
#(
  parameter int unsigned GRID_W        = DEF_GRID_W,
  parameter int unsigned GRID_H        = DEF_GRID_H,
  parameter int unsigned CELL_W        = DEF_CELL_W,
  parameter int unsigned CELL_H        = DEF_CELL_H,
  parameter int unsigned START_COL     = DEF_START_COL,
  parameter int unsigned START_ROW     = DEF_START_ROW,
  parameter int unsigned HOP_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned DEATH_CYCLES  = 16,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned SCORE_BITS    = 8
) (
  input  logic                      i_Clk,
  input  logic                      reset,
  input  logic                      i_Up,
  input  logic                      i_Down,
  input  logic                      i_Left,
  input  logic                      i_Right,
  input  logic                      i_Hazard,
  output logic [$clog2(GRID_W)-1:0] o_Col,
  output logic [$clog2(GRID_H)-1:0] o_Row,
  output logic [9:0]                o_Frog_X,
  output logic [9:0]                o_Frog_Y,
  output logic                      o_Moved,
  output logic                      o_Goal,
  output logic                      o_Dead,
  output logic                      o_Game_Over,
  output logic [2:0]                o_Lives,
  output logic [SCORE_BITS-1:0]     o_Score
);

  localparam int unsigned COL_W = $clog2(GRID_W);
  localparam int unsigned ROW_W = $clog2(GRID_H);
  localparam int unsigned HOP_W = $clog2(HOP_CYCLES + 1);
  localparam int unsigned DTH_W = $clog2(DEATH_CYCLES + 1);
  localparam logic [COL_W-1:0] COL_START = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(START_ROW);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(GRID_H - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, tgt_col;
  logic [ROW_W-1:0] row_q, row_d, tgt_row;
  logic [9:0]       x_q, y_q;
  logic             moved_q, moved_d;
  logic             goal_q, goal_d;
  logic             dead_q, over_q;
  logic [2:0]       lives_q, lives_d;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic [HOP_W-1:0] hcnt_q, hcnt_d;
  logic [DTH_W-1:0] dcnt_q, dcnt_d;
  logic             pend_q, pend_d;
  logic             legal;
  logic             hop_c;
  dir_t             dir_c;
  logic             trig_c;

  dir_edge_repeat #(
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dir (
    .i_Clk  (i_Clk),
    .reset  (reset),
    .up     (i_Up),
    .down   (i_Down),
    .left   (i_Left),
    .right  (i_Right),
    .en     (state_q == ST_IDLE),
    .hop    (hop_c),
    .dir_c  (dir_c),
    .trig_c (trig_c)
  );

  // Target cell for the selected direction; walls block without substitution.
  always_comb begin
    tgt_col = col_q;
    tgt_row = row_q;
    legal   = 1'b0;
    case (dir_c)
      DIR_UP:    if (row_q != '0)     begin legal = 1'b1; tgt_row = row_q - ROW_W'(1); end
      DIR_DOWN:  if (row_q != ROW_MAX) begin legal = 1'b1; tgt_row = row_q + ROW_W'(1); end
      DIR_LEFT:  if (col_q != '0)     begin legal = 1'b1; tgt_col = col_q - COL_W'(1); end
      DIR_RIGHT: if (col_q != COL_MAX) begin legal = 1'b1; tgt_col = col_q + COL_W'(1); end
      default: ;
    endcase
  end

  // Next-state and datapath updates; hazard outranks any same-cycle hop.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    moved_d = 1'b0;
    goal_d  = 1'b0;
    lives_d = lives_q;
    score_d = score_q;
    hcnt_d  = hcnt_q;
    dcnt_d  = dcnt_q;
    pend_d  = pend_q;
    hop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Hazard) begin
          lives_d = lives_q - 3'd1;
          dcnt_d  = '0;
          pend_d  = 1'b0;
          state_d = ST_DEAD;
        end else if (trig_c && legal) begin
          hop_c   = 1'b1;
          col_d   = tgt_col;
          row_d   = tgt_row;
          moved_d = 1'b1;
          hcnt_d  = '0;
          state_d = ST_HOP;
          if (tgt_row == '0) begin
            goal_d  = 1'b1;
            pend_d  = 1'b1;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_BITS'(1);
          end
        end
      end
      ST_HOP: begin
        if (i_Hazard) begin
          lives_d = lives_q - 3'd1;
          dcnt_d  = '0;
          pend_d  = 1'b0;
          state_d = ST_DEAD;
        end else if (hcnt_q == HOP_W'(HOP_CYCLES - 1)) begin
          hcnt_d  = '0;
          state_d = ST_IDLE;
          if (pend_q) begin
            col_d  = COL_START;
            row_d  = ROW_START;
            pend_d = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + HOP_W'(1);
        end
      end
      ST_DEAD: begin
        if (dcnt_q == DTH_W'(DEATH_CYCLES - 1)) begin
          dcnt_d = '0;
          if (lives_q != 3'd0) begin
            col_d   = COL_START;
            row_d   = ROW_START;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_OVER;
          end
        end else begin
          dcnt_d = dcnt_q + DTH_W'(1);
        end
      end
      default: ;
    endcase
  end

  // State and output registers; pixel coordinates track the next cell.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= COL_START;
      row_q   <= ROW_START;
      x_q     <= 10'(START_COL * CELL_W);
      y_q     <= 10'(START_ROW * CELL_H);
      moved_q <= 1'b0;
      goal_q  <= 1'b0;
      dead_q  <= 1'b0;
      over_q  <= 1'b0;
      lives_q <= 3'(LIVES);
      score_q <= '0;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= 10'(col_d * CELL_W);
      y_q     <= 10'(row_d * CELL_H);
      moved_q <= moved_d;
      goal_q  <= goal_d;
      dead_q  <= (state_d == ST_DEAD);
      over_q  <= (state_d == ST_OVER);
      lives_q <= lives_d;
      score_q <= score_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign o_Col       = col_q;
  assign o_Row       = row_q;
  assign o_Frog_X    = x_q;
  assign o_Frog_Y    = y_q;
  assign o_Moved     = moved_q;
  assign o_Goal      = goal_q;
  assign o_Dead      = dead_q;
  assign o_Game_Over = over_q;
  assign o_Lives     = lives_q;
  assign o_Score     = score_q;

endmodule

// File: tb/tb_frog_grid_mover.sv
// Scoreboard bench for frog_grid_mover: expected hops queued at stimulus, checked on o_Moved.
module tb_frog_grid_mover;

  logic       i_Clk, reset;
  logic       i_Up, i_Down, i_Left, i_Right, i_Hazard;
  logic [4:0] o_Col;
  logic [3:0] o_Row;
  logic [9:0] o_Frog_X, o_Frog_Y;
  logic       o_Moved, o_Goal, o_Dead, o_Game_Over;
  logic [2:0] o_Lives;
  logic [7:0] o_Score;

  typedef struct {int col; int row; bit goal;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] D_UP = 4'b1000, D_DOWN = 4'b0100, D_LEFT = 4'b0010,
                         D_RIGHT = 4'b0001, D_NONE = 4'b0000;

  frog_grid_mover dut (
    .i_Clk(i_Clk), .reset(reset), .i_Up(i_Up), .i_Down(i_Down), .i_Left(i_Left),
    .i_Right(i_Right), .i_Hazard(i_Hazard), .o_Col(o_Col), .o_Row(o_Row),
    .o_Frog_X(o_Frog_X), .o_Frog_Y(o_Frog_Y), .o_Moved(o_Moved), .o_Goal(o_Goal),
    .o_Dead(o_Dead), .o_Game_Over(o_Game_Over), .o_Lives(o_Lives), .o_Score(o_Score)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Scoreboard monitor: every o_Moved pulse must match the oldest queued hop.
  always @(negedge i_Clk) begin
    if (!reset && o_Moved) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_move: got col=%0d row=%0d, required no hop", o_Col, o_Row);
      end else begin
        mon_e = sb.pop_front();
        if (int'(o_Col) !== mon_e.col || int'(o_Row) !== mon_e.row ||
            int'(o_Frog_X) !== mon_e.col * 32 || int'(o_Frog_Y) !== mon_e.row * 32 ||
            o_Goal !== mon_e.goal) begin
          n_fail++;
          $display("FAIL hop_result: got col=%0d row=%0d x=%0d y=%0d goal=%0b, required col=%0d row=%0d x=%0d y=%0d goal=%0b",
                   o_Col, o_Row, o_Frog_X, o_Frog_Y, o_Goal,
                   mon_e.col, mon_e.row, mon_e.col * 32, mon_e.row * 32, mon_e.goal);
        end
      end
    end
  end

  task automatic push(input int c, input int r, input bit g);
    exp_t e;
    e.col = c; e.row = r; e.goal = g;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Drive one sampling edge of stimulus, then release.
  task automatic pulse(input logic [3:0] d, input logic hz);
    {i_Up, i_Down, i_Left, i_Right} = d;
    i_Hazard = hz;
    @(posedge i_Clk);
    #1;
    {i_Up, i_Down, i_Left, i_Right} = D_NONE;
    i_Hazard = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    reset = 1'b1;
    #2;
    @(negedge i_Clk);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({o_Col, o_Row, o_Frog_X, o_Frog_Y} !== {5'd10, 4'd14, 10'd320, 10'd448}) begin
      n_fail++;
      $display("FAIL reset_pos: got col=%0d row=%0d x=%0d y=%0d, required 10 14 320 448",
               o_Col, o_Row, o_Frog_X, o_Frog_Y);
    end
    n_tests++;
    if ({o_Lives, o_Score} !== {3'd3, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_lives_score: got lives=%0d score=%0d, required 3 0", o_Lives, o_Score);
    end
    n_tests++;
    if ({o_Moved, o_Goal, o_Dead, o_Game_Over} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000", {o_Moved, o_Goal, o_Dead, o_Game_Over});
    end
  endtask

  task automatic test_single_hop();
    push(10, 13, 0);
    pulse(D_UP, 0);
    n_tests++;
    if (o_Moved !== 1'b1 || o_Frog_Y !== 10'd416) begin
      n_fail++;
      $display("FAIL hop_latency: got moved=%0b y=%0d, required 1 416", o_Moved, o_Frog_Y);
    end
    tick(1);
    n_tests++;
    if (o_Moved !== 1'b0) begin
      n_fail++;
      $display("FAIL moved_pulse_width: got %0b, required 0", o_Moved);
    end
    tick(2);
    pulse(D_DOWN, 0);          // sampled on the last cooldown edge: discarded
    tick(6);
    n_tests++;
    if (o_Row !== 4'd13) begin
      n_fail++;
      $display("FAIL cooldown_discard: got row=%0d, required 13", o_Row);
    end
    push(10, 12, 0);
    pulse(D_UP, 0);
    tick(4);
    push(10, 13, 0);
    pulse(D_DOWN, 0);          // first IDLE edge after cooldown: accepted
    n_tests++;
    if (o_Row !== 4'd13) begin
      n_fail++;
      $display("FAIL idle_after_cooldown: got row=%0d, required 13", o_Row);
    end
    tick(6);
  endtask

  task automatic test_hold_repeat();
    int moves = 0;
    for (int c = 11; c <= 19; c++) push(c, 13, 0);
    i_Right = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
      if (o_Moved) begin
        n_tests++;
        if (i !== moves * 12) begin
          n_fail++;
          $display("FAIL repeat_timing: hop %0d at cycle %0d, required cycle %0d", moves, i, moves * 12);
        end
        moves++;
      end
    end
    i_Right = 1'b0;
    tick(1);
    n_tests++;
    if (moves !== 9 || o_Col !== 5'd19) begin
      n_fail++;
      $display("FAIL wall_clamp: got moves=%0d col=%0d, required 9 19", moves, o_Col);
    end
    tick(6);
  endtask

  task automatic test_priority();
    push(19, 12, 0);
    pulse(D_UP | D_LEFT, 0);
    n_tests++;
    if ({o_Col, o_Row} !== {5'd19, 4'd12}) begin
      n_fail++;
      $display("FAIL up_over_left: got col=%0d row=%0d, required 19 12", o_Col, o_Row);
    end
    tick(6);
  endtask

  task automatic test_goal();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      push(10, 14 - k, (k == 14));
      pulse(D_UP, 0);
      if (k < 14) tick(5);
    end
    n_tests++;
    if (o_Goal !== 1'b1 || o_Score !== 8'd1 || o_Frog_Y !== 10'd0) begin
      n_fail++;
      $display("FAIL goal_pulse: got goal=%0b score=%0d y=%0d, required 1 1 0", o_Goal, o_Score, o_Frog_Y);
    end
    tick(3);
    n_tests++;
    if (o_Row !== 4'd0) begin
      n_fail++;
      $display("FAIL goal_row_hold: got row=%0d, required 0", o_Row);
    end
    tick(1);
    n_tests++;
    if ({o_Col, o_Row, o_Frog_X, o_Frog_Y, o_Score} !== {5'd10, 4'd14, 10'd320, 10'd448, 8'd1}) begin
      n_fail++;
      $display("FAIL goal_respawn: got col=%0d row=%0d x=%0d y=%0d score=%0d, required 10 14 320 448 1",
               o_Col, o_Row, o_Frog_X, o_Frog_Y, o_Score);
    end
    tick(2);
  endtask

  task automatic test_hazard();
    int dcount;
    push(10, 13, 0);
    pulse(D_UP, 0);
    tick(6);
    pulse(D_DOWN, 1);
    n_tests++;
    if ({o_Dead, o_Lives, o_Row, o_Moved} !== {1'b1, 3'd2, 4'd13, 1'b0}) begin
      n_fail++;
      $display("FAIL hazard_beats_hop: got dead=%0b lives=%0d row=%0d moved=%0b, required 1 2 13 0",
               o_Dead, o_Lives, o_Row, o_Moved);
    end
    dcount = 1;
    for (int i = 0; i < 25; i++) begin
      i_Hazard = (i == 3);
      i_Up     = (i == 6);
      tick(1);
      if (o_Dead) dcount++;
    end
    i_Hazard = 1'b0;
    i_Up     = 1'b0;
    n_tests++;
    if (dcount !== 16) begin
      n_fail++;
      $display("FAIL dead_duration: got %0d cycles, required 16", dcount);
    end
    n_tests++;
    if ({o_Frog_X, o_Frog_Y, o_Lives, o_Dead} !== {10'd320, 10'd448, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL dead_respawn: got x=%0d y=%0d lives=%0d dead=%0b, required 320 448 2 0",
               o_Frog_X, o_Frog_Y, o_Lives, o_Dead);
    end
  endtask

  task automatic test_game_over();
    do_reset();
    for (int h = 0; h < 3; h++) begin
      pulse(D_NONE, 1);
      tick(19);
    end
    n_tests++;
    if ({o_Lives, o_Game_Over, o_Dead} !== {3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL game_over: got lives=%0d over=%0b dead=%0b, required 0 1 0", o_Lives, o_Game_Over, o_Dead);
    end
    pulse(D_UP, 0);
    tick(2);
    pulse(D_NONE, 1);
    tick(2);
    n_tests++;
    if ({o_Row, o_Lives, o_Game_Over} !== {4'd14, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL over_ignores_inputs: got row=%0d lives=%0d over=%0b, required 14 0 1", o_Row, o_Lives, o_Game_Over);
    end
    @(negedge i_Clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({o_Lives, o_Game_Over, o_Col, o_Row} !== {3'd3, 1'b0, 5'd10, 4'd14}) begin
      n_fail++;
      $display("FAIL reset_in_over: got lives=%0d over=%0b col=%0d row=%0d, required 3 0 10 14",
               o_Lives, o_Game_Over, o_Col, o_Row);
    end
    @(negedge i_Clk);
    reset = 1'b0;
    tick(1);
    push(10, 13, 0);
    pulse(D_UP, 0);
    tick(5);
    pulse(D_NONE, 1);
    tick(5);
    n_tests++;
    if ({o_Dead, o_Lives, o_Row} !== {1'b1, 3'd2, 4'd13}) begin
      n_fail++;
      $display("FAIL mid_dead_state: got dead=%0b lives=%0d row=%0d, required 1 2 13", o_Dead, o_Lives, o_Row);
    end
    @(negedge i_Clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({o_Dead, o_Lives, o_Col, o_Row, o_Frog_Y} !== {1'b0, 3'd3, 5'd10, 4'd14, 10'd448}) begin
      n_fail++;
      $display("FAIL reset_in_dead: got dead=%0b lives=%0d col=%0d row=%0d y=%0d, required 0 3 10 14 448",
               o_Dead, o_Lives, o_Col, o_Row, o_Frog_Y);
    end
    @(negedge i_Clk);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    {i_Up, i_Down, i_Left, i_Right, i_Hazard} = 5'b0;
    #3;
    test_reset();
    @(negedge i_Clk);
    reset = 1'b0;
    tick(1);
    test_single_hop();
    test_hold_repeat();
    test_priority();
    test_goal();
    test_hazard();
    test_game_over();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL missing_hops: got %0d hops still queued, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
